// File: rtl/sad_best_match_pkg.sv
// Shared motion-estimation definitions for the SAD consumer and the motion-vector writer.
// Holds default datapath widths, default search-window geometry, the FSM state type and
// the motion-vector record passed downstream.
package sad_best_match_pkg;

  localparam int unsigned SadWidthDef = 12;  // 4x4 block of 8-bit pixels
  localparam int unsigned SearchWDef  = 16;
  localparam int unsigned SearchHDef  = 16;
  localparam int unsigned XWidthDef   = 4;
  localparam int unsigned YWidthDef   = 4;

  typedef enum logic {
    StAccum,
    StHold
  } state_e;

  // Motion vector as consumed by the writer (default geometry).
  typedef struct packed {
    logic signed [XWidthDef:0] dx;
    logic signed [YWidthDef:0] dy;
    logic [SadWidthDef-1:0]    sad;
  } mv_t;

endpackage

// File: rtl/sad_best_match_if.sv
// SAD beat stream plus result handshake.
// slave : block side (consumes beats, produces results)
// master: upstream/downstream side (produces beats, consumes results)
interface sad_best_match_if #(
  parameter int unsigned SAD_WIDTH = 12,
  parameter int unsigned X_WIDTH   = 4,
  parameter int unsigned Y_WIDTH   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SAD_WIDTH-1:0] in_sad;
  logic                 in_last;
  logic                 res_valid;
  logic                 res_ready;
  logic [SAD_WIDTH-1:0] res_sad;
  logic [X_WIDTH:0]     res_dx;
  logic [Y_WIDTH:0]     res_dy;

  modport slave (
    input  in_valid, in_sad, in_last, res_ready,
    output in_ready, res_valid, res_sad, res_dx, res_dy
  );

  modport master (
    output in_valid, in_sad, in_last, res_ready,
    input  in_ready, res_valid, res_sad, res_dx, res_dy
  );
endinterface

// File: rtl/raster_pos_counter.sv
// Raster column/row position within a search window.
// Ports: clk/rst_n, clear_i (sync reset to origin), step_i (advance one candidate),
//        col_o/row_o (current position), first_o (at origin), last_o (at final candidate).
module raster_pos_counter #(
  parameter int unsigned SEARCH_W = 16,
  parameter int unsigned SEARCH_H = 16,
  parameter int unsigned X_WIDTH  = 4,
  parameter int unsigned Y_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [X_WIDTH-1:0] col_o,
  output logic [Y_WIDTH-1:0] row_o,
  output logic               first_o,
  output logic               last_o
);
  localparam logic [X_WIDTH-1:0] ColMax = X_WIDTH'(SEARCH_W - 1);
  localparam logic [Y_WIDTH-1:0] RowMax = Y_WIDTH'(SEARCH_H - 1);

  logic [X_WIDTH-1:0] col_q, col_d;
  logic [Y_WIDTH-1:0] row_q, row_d;
  logic               col_end, row_end;

  assign col_end = (col_q == ColMax);
  assign row_end = (row_q == RowMax);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + Y_WIDTH'(1);
      end else begin
        col_d = col_q + X_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign first_o = (col_q == '0) && (row_q == '0);
  assign last_o  = col_end && row_end;
endmodule

// File: rtl/sad_best_match.sv
// Best-match selector: tracks the minimum SAD over a raster-ordered search window and
// presents the winning motion vector once the final candidate has been accepted.
// Ports: clk/rst_n, clear_i (sync abort of current window), sad_if (beat stream in,
//        result out), frame_err_o (sticky: in_last disagreed with internal position).
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int unsigned SAD_WIDTH = SadWidthDef,
  parameter int unsigned SEARCH_W  = SearchWDef,
  parameter int unsigned SEARCH_H  = SearchHDef,
  parameter int unsigned X_WIDTH   = XWidthDef,
  parameter int unsigned Y_WIDTH   = YWidthDef
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  sad_best_match_if.slave sad_if,
  output logic            frame_err_o
);
  localparam logic [X_WIDTH:0] DxOff = (X_WIDTH + 1)'(SEARCH_W / 2);
  localparam logic [Y_WIDTH:0] DyOff = (Y_WIDTH + 1)'(SEARCH_H / 2);

  state_e               state_q, state_d;
  logic [SAD_WIDTH-1:0] best_sad_q, best_sad_d;
  logic [X_WIDTH-1:0]   best_col_q, best_col_d;
  logic [Y_WIDTH-1:0]   best_row_q, best_row_d;
  logic [SAD_WIDTH-1:0] res_sad_q, res_sad_d;
  logic [X_WIDTH:0]     res_dx_q, res_dx_d;
  logic [Y_WIDTH:0]     res_dy_q, res_dy_d;
  logic                 frame_err_q, frame_err_d;

  logic [X_WIDTH-1:0]   col;
  logic [Y_WIDTH-1:0]   row;
  logic                 first, last;
  logic                 accept, take;
  logic [SAD_WIDTH-1:0] sel_sad;
  logic [X_WIDTH-1:0]   sel_col;
  logic [Y_WIDTH-1:0]   sel_row;

  // in_ready depends only on registered state, so no combinational path from inputs.
  assign accept = sad_if.in_valid && (state_q == StAccum);

  raster_pos_counter #(
    .SEARCH_W (SEARCH_W),
    .SEARCH_H (SEARCH_H),
    .X_WIDTH  (X_WIDTH),
    .Y_WIDTH  (Y_WIDTH)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .step_i  (accept && !clear_i),
    .col_o   (col),
    .row_o   (row),
    .first_o (first),
    .last_o  (last)
  );

  // Strict less-than keeps the earliest candidate on ties.
  assign take    = first || (sad_if.in_sad < best_sad_q);
  assign sel_sad = take ? sad_if.in_sad : best_sad_q;
  assign sel_col = take ? col : best_col_q;
  assign sel_row = take ? row : best_row_q;

  always_comb begin
    state_d     = state_q;
    best_sad_d  = best_sad_q;
    best_col_d  = best_col_q;
    best_row_d  = best_row_q;
    res_sad_d   = res_sad_q;
    res_dx_d    = res_dx_q;
    res_dy_d    = res_dy_q;
    frame_err_d = frame_err_q;
    if (clear_i) begin
      // Result data is left as-is; it is simply no longer valid.
      state_d     = StAccum;
      frame_err_d = 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            best_sad_d = sel_sad;
            best_col_d = sel_col;
            best_row_d = sel_row;
            if (sad_if.in_last != last) frame_err_d = 1'b1;
            if (last) begin
              res_sad_d = sel_sad;
              res_dx_d  = {1'b0, sel_col} - DxOff;
              res_dy_d  = {1'b0, sel_row} - DyOff;
              state_d   = StHold;
            end
          end
        end
        StHold: begin
          if (sad_if.res_ready) state_d = StAccum;
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      best_sad_q  <= '0;
      best_col_q  <= '0;
      best_row_q  <= '0;
      res_sad_q   <= '0;
      res_dx_q    <= '0;
      res_dy_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_sad_q  <= best_sad_d;
      best_col_q  <= best_col_d;
      best_row_q  <= best_row_d;
      res_sad_q   <= res_sad_d;
      res_dx_q    <= res_dx_d;
      res_dy_q    <= res_dy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sad_if.in_ready  = (state_q == StAccum);
  assign sad_if.res_valid = (state_q == StHold);
  assign sad_if.res_sad   = res_sad_q;
  assign sad_if.res_dx    = res_dx_q;
  assign sad_if.res_dy    = res_dy_q;
  assign frame_err_o      = frame_err_q;
endmodule
